sdram_arbit: RTL

- Central arbiter between the SDRAM init sequencer, the write engine (sdram_write), the read engine and an internal auto-refresh sequencer.
- Grants the SDRAM command/address/data bus to exactly one requester at a time.
- Generates the periodic refresh request that the write and read engines observe.
- Muxes the granted requester's cmd/addr/bank/data onto the SDRAM pins.

---
 rtl/sdram_arbit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: init handoff, periodic auto-refresh, write/read grants and pin mux.
// Optional SDRAM_ARB_RR_EN: round-robin write/read tie-break instead of write-first.
module sdram_arbit #(
  parameter int REF_CNT_MAX = 780,
  parameter int TRP_CYC     = 2,
  parameter int TRFC_CYC    = 7
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  output logic        ref_req,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic [15:0] wr_data,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  localparam int REF_W     = $clog2(REF_CNT_MAX);
  localparam int AREF_LAST = TRP_CYC + 1 + TRFC_CYC;
  localparam int AREF_W    = $clog2(AREF_LAST + 1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_t;

  state_t              state_q, state_d;
  logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
  logic                ref_req_q, ref_req_d;
  logic [AREF_W-1:0]   aref_cnt_q, aref_cnt_d;
  logic                ref_wrap;
  logic                aref_done;
  logic                wr_wins;
`ifdef SDRAM_ARB_RR_EN
  logic                last_grant_q, last_grant_d;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      ref_cnt_q    <= '0;
      ref_req_q    <= 1'b0;
      aref_cnt_q   <= '0;
`ifdef SDRAM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_req_q    <= ref_req_d;
      aref_cnt_q   <= aref_cnt_d;
`ifdef SDRAM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Refresh timer and the AREF sequence sub-counter.
  always_comb begin
    ref_wrap   = (state_q != S_INIT) && (ref_cnt_q == REF_W'(REF_CNT_MAX - 1));
    ref_cnt_d  = ref_cnt_q;
    if (state_q != S_INIT) ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;

    aref_done  = (state_q == S_AREF) && (aref_cnt_q == AREF_W'(AREF_LAST));
    aref_cnt_d = ((state_q == S_AREF) && !aref_done) ? aref_cnt_q + 1'b1 : '0;

    // A wrap that lands while a request is still pending is simply absorbed.
    ref_req_d  = ref_req_q;
    if (aref_done)     ref_req_d = 1'b0;
    else if (ref_wrap) ref_req_d = 1'b1;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
`ifdef SDRAM_ARB_RR_EN
    last_grant_d = last_grant_q;
    wr_wins      = wr_req && !(rd_req && last_grant_q);
`else
    wr_wins      = wr_req;
`endif
    unique case (state_q)
      S_INIT:  if (init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (ref_req_q) begin
          state_d = S_AREF;
        end else if (wr_wins) begin
          state_d = S_WRITE;
`ifdef SDRAM_ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (rd_req) begin
          state_d = S_READ;
`ifdef SDRAM_ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      S_AREF:  if (aref_done)   state_d = S_ARBIT;
      S_WRITE: if (flag_wr_end) state_d = S_ARBIT;
      S_READ:  if (flag_rd_end) state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  // Pin mux; reset forces NOP immediately instead of waiting for the init sequencer's command.
  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_addr   = '0;
    sdram_bank   = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_INIT: begin
          sdram_cmd  = init_cmd;
          sdram_addr = init_addr;
        end
        S_AREF: begin
          if (aref_cnt_q == '0) begin
            sdram_cmd  = CMD_PRE;
            sdram_addr = 12'h400;
          end else if (aref_cnt_q == AREF_W'(TRP_CYC + 1)) begin
            sdram_cmd  = CMD_AREF;
          end
        end
        S_WRITE: begin
          sdram_cmd    = wr_cmd;
          sdram_addr   = wr_addr;
          sdram_bank   = wr_bank;
          sdram_dq_out = wr_data;
          sdram_dq_oe  = 1'b1;
        end
        S_READ: begin
          sdram_cmd  = rd_cmd;
          sdram_addr = rd_addr;
          sdram_bank = rd_bank;
        end
        default: ;
      endcase
    end
  end

  assign ref_req = ref_req_q;
  assign wr_en   = (state_q == S_WRITE);
  assign rd_en   = (state_q == S_READ);

endmodule
